fifo_read_arbiter: RTL and testbench

- Round-robin arbiter and burst sequencer for the read port of the asynchronous FIFO.
- Lives in the read clock domain, between NREQ consumers and the FIFO read-pointer/memory side.
- Grants the port to one consumer at a time for a committed burst of 1..2^BLEN_W words.
- Drives the FIFO read enable only while the FIFO is not empty, and returns read data tagged to the owning consumer.

---
 rtl/fifo_read_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_read_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// Round-robin read-port arbiter and burst sequencer for the async FIFO read domain.
// One consumer owns the port for a committed burst of req_len+1 words; read data is tagged to the owner.
module fifo_read_arbiter #(
   parameter int NREQ   = 4,
   parameter int BLEN_W = 4,
   parameter int DWIDTH = 8
) (
   input  logic                     r_clk,
   input  logic                     r_rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*BLEN_W-1:0]   req_len,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          done,
   input  logic                     fifo_empty,
   output logic                     fifo_r_en,
   input  logic [DWIDTH-1:0]        fifo_rdata,
   output logic [DWIDTH-1:0]        rdata,
   output logic [NREQ-1:0]          rdata_valid
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, BURST, LAST} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   last, owner, winner;
   logic               found;
   logic [BLEN_W-1:0]  remaining, win_len;

   function automatic logic [IDX_W-1:0] wrap_idx(input int v);
      return IDX_W'(v % NREQ);
   endfunction

   // Search starts just after the previous owner, so it ends up with lowest priority.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[wrap_idx(int'(last) + k)]) begin
            found  = 1'b1;
            winner = wrap_idx(int'(last) + k);
         end
      end
   end

   always_comb begin
      win_len = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IDX_W'(i)) win_len = req_len[i*BLEN_W +: BLEN_W];
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      fifo_r_en = 1'b0;
      done      = '0;
      case (state)
         IDLE: if (found) state_nxt = BURST;
         BURST: begin
            fifo_r_en = !fifo_empty && !r_rst;
            if (!fifo_empty && remaining == '0) state_nxt = LAST;
         end
         LAST: begin
            done      = grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         state       <= IDLE;
         grant       <= '0;
         last        <= IDX_W'(NREQ - 1);
         owner       <= '0;
         remaining   <= '0;
         rdata       <= '0;
         rdata_valid <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (found) begin
               grant     <= NREQ'(1) << winner;
               owner     <= winner;
               remaining <= win_len;
            end
            BURST: if (fifo_r_en && remaining != '0) remaining <= remaining - 1'b1;
            LAST: begin
               grant <= '0;
               last  <= owner;
            end
            default: ;
         endcase
         // Word read this cycle is captured on the closing edge and tagged to the owner.
         if (fifo_r_en) rdata <= fifo_rdata;
         rdata_valid <= fifo_r_en ? grant : '0;
      end
   end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed, table-driven bench for fifo_read_arbiter with a show-ahead FIFO read-side model.
module tb_fifo_read_arbiter;

   logic        r_clk = 1'b0;
   logic        r_rst = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] req_len = '0;
   logic [3:0]  grant, done, rdata_valid;
   logic        fifo_empty = 1'b0;
   logic        fifo_r_en;
   logic [7:0]  fifo_rdata, rdata;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_ptr   = 0;
   int exp_rd_cnt = 0;
   logic [7:0] exp_word = '0;

   fifo_read_arbiter #(.NREQ(4), .BLEN_W(4), .DWIDTH(8)) dut (
      .r_clk(r_clk), .r_rst(r_rst), .req(req), .req_len(req_len),
      .grant(grant), .done(done), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
      .fifo_rdata(fifo_rdata), .rdata(rdata), .rdata_valid(rdata_valid)
   );

   always #5 r_clk = ~r_clk;

   function automatic logic [7:0] word(input int n);
      return 8'((n * 37 + 11) % 256);
   endfunction

   // Head of FIFO is presented continuously; a read pops it on the edge.
   assign fifo_rdata = word(rd_ptr);
   always @(posedge r_clk) if (fifo_r_en) rd_ptr <= rd_ptr + 1;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] len;
      logic        empty;
      logic [3:0]  e_grant;
      logic        e_ren;
      logic [3:0]  e_done;
      logic [3:0]  e_valid;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] rq, input logic [15:0] ln, input logic em,
                               input logic [3:0] g, input logic r, input logic [3:0] d,
                               input logic [3:0] v);
      vec_t t;
      t.req = rq; t.len = ln; t.empty = em;
      t.e_grant = g; t.e_ren = r; t.e_done = d; t.e_valid = v;
      return t;
   endfunction

   task automatic add(input logic [3:0] rq, input logic [15:0] ln, input logic em,
                      input logic [3:0] g, input logic r, input logic [3:0] d, input logic [3:0] v);
      vecs.push_back(mk(rq, ln, em, g, r, d, v));
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check mid-cycle, advance past the next rising edge.
   task automatic cycle(input vec_t v, input string tag);
      req = v.req; req_len = v.len; fifo_empty = v.empty;
      @(negedge r_clk);
      check({tag, " grant"},       32'(grant),       32'(v.e_grant));
      check({tag, " fifo_r_en"},   32'(fifo_r_en),   32'(v.e_ren));
      check({tag, " done"},        32'(done),        32'(v.e_done));
      check({tag, " rdata_valid"}, 32'(rdata_valid), 32'(v.e_valid));
      if (v.e_valid != '0) check({tag, " rdata"}, 32'(rdata), 32'(exp_word));
      if (v.e_ren) begin
         exp_word = word(exp_rd_cnt);
         exp_rd_cnt++;
      end
      @(posedge r_clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] o;

      // Round robin with all four requesting, one-word bursts, starting from reset priority.
      add(4'hF, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      for (int w = 0; w < 5; w++) begin
         o = 4'b0001 << (w % 4);
         add(4'hF, 16'h0000, 1'b0, o, 1'b1, 4'h0, 4'h0);
         add(4'hF, 16'h0000, 1'b0, o, 1'b0, o, o);
         add((w < 4) ? 4'hF : 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      end
      // Consumer 0, three-word burst.
      add(4'h1, 16'h0002, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      add(4'h0, 16'h0002, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0);
      add(4'h0, 16'h0002, 1'b0, 4'h1, 1'b1, 4'h0, 4'h1);
      add(4'h0, 16'h0002, 1'b0, 4'h1, 1'b1, 4'h0, 4'h1);
      add(4'h0, 16'h0002, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1);
      add(4'h0, 16'h0002, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      // Consumer 2, four words with empty stalls, including a stall on the final word.
      add(4'h4, 16'h0300, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      add(4'h0, 16'h0300, 1'b0, 4'h4, 1'b1, 4'h0, 4'h0);
      add(4'h0, 16'h0300, 1'b1, 4'h4, 1'b0, 4'h0, 4'h4);
      add(4'h0, 16'h0300, 1'b1, 4'h4, 1'b0, 4'h0, 4'h0);
      add(4'h0, 16'h0300, 1'b0, 4'h4, 1'b1, 4'h0, 4'h0);
      add(4'h0, 16'h0300, 1'b0, 4'h4, 1'b1, 4'h0, 4'h4);
      add(4'h0, 16'h0300, 1'b1, 4'h4, 1'b0, 4'h0, 4'h4);
      add(4'h0, 16'h0300, 1'b0, 4'h4, 1'b1, 4'h0, 4'h0);
      add(4'h0, 16'h0300, 1'b0, 4'h4, 1'b0, 4'h4, 4'h4);
      add(4'h0, 16'h0300, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      // Consumer 1, maximum burst of 16 words.
      add(4'h2, 16'h00F0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      add(4'h0, 16'h00F0, 1'b0, 4'h2, 1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 15; i++) add(4'h0, 16'h00F0, 1'b0, 4'h2, 1'b1, 4'h0, 4'h2);
      add(4'h0, 16'h00F0, 1'b0, 4'h2, 1'b0, 4'h2, 4'h2);
      add(4'h0, 16'h00F0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      // Consumer 3, five words; owner drops req and req_len changes mid-burst while consumer 0 waits.
      add(4'h8, 16'h4000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      add(4'h8, 16'h4000, 1'b0, 4'h8, 1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 4; i++) add(4'h1, 16'h0000, 1'b0, 4'h8, 1'b1, 4'h0, 4'h8);
      add(4'h1, 16'h0000, 1'b0, 4'h8, 1'b0, 4'h8, 4'h8);
      add(4'h1, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
      add(4'h0, 16'h0000, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0);
      add(4'h0, 16'h0000, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1);
      add(4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);

      // Reset state.
      #2;
      check("reset grant",       32'(grant),       32'h0);
      check("reset done",        32'(done),        32'h0);
      check("reset fifo_r_en",   32'(fifo_r_en),   32'h0);
      check("reset rdata_valid", 32'(rdata_valid), 32'h0);
      check("reset rdata",       32'(rdata),       32'h0);
      @(posedge r_clk);
      #1;
      r_rst = 1'b0;

      foreach (vecs[i]) cycle(vecs[i], $sformatf("vec%0d", i));

      // Reset asserted mid-burst clears outputs without a clock edge.
      cycle(mk(4'h1, 16'h0007, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0), "rst c0");
      cycle(mk(4'h0, 16'h0007, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0), "rst c1");
      req = 4'h0;
      #1;
      check("pre-rst fifo_r_en",   32'(fifo_r_en),   32'h1);
      check("pre-rst grant",       32'(grant),       32'h1);
      check("pre-rst rdata_valid", 32'(rdata_valid), 32'h1);
      check("pre-rst rdata",       32'(rdata),       32'(exp_word));
      r_rst = 1'b1;
      #1;
      check("async rst fifo_r_en",   32'(fifo_r_en),   32'h0);
      check("async rst grant",       32'(grant),       32'h0);
      check("async rst rdata_valid", 32'(rdata_valid), 32'h0);
      check("async rst rdata",       32'(rdata),       32'h0);
      @(posedge r_clk);
      #1;
      check("held rst fifo_r_en", 32'(fifo_r_en), 32'h0);
      r_rst = 1'b0;
      req = 4'hF;
      req_len = 16'h0000;
      @(negedge r_clk);
      check("post-rst idle grant", 32'(grant), 32'h0);
      @(posedge r_clk);
      #1;
      cycle(mk(4'h0, 16'h0000, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0), "post-rst burst");
      cycle(mk(4'h0, 16'h0000, 1'b0, 4'h1, 1'b0, 4'h1, 4'h1), "post-rst last");
      cycle(mk(4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0), "post-rst idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
